// File: rtl/gnn_mp_engine.sv
// Time-multiplexed two-layer graph neural network engine.
// A job (features, adjacency, both weight sets) is captured on the input
// handshake. Layer 1 then evaluates one node per cycle into a hidden register
// file, layer 2 does the same into the output registers, and the finished
// result is held until the consumer takes it.
module gnn_mp_engine #(
  parameter int N_NODES = 4,
  parameter int N_IN    = 4,
  parameter int N_HID   = 4,
  parameter int N_OUT   = 2,
  parameter int XW      = 5,
  parameter int WW      = 5
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [N_NODES*N_IN*XW-1:0]              x_flat,
  input  logic [N_NODES*N_NODES-1:0]              adj,
  input  logic [N_IN*N_HID*WW-1:0]                w1_flat,
  input  logic [N_HID*N_OUT*WW-1:0]               w2_flat,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [N_NODES*N_OUT*(XW+WW+$clog2(N_NODES)+$clog2(N_IN)+WW+$clog2(N_NODES)+$clog2(N_HID))-1:0] out_flat
);

  // Widths chosen so that the worst-case sums can neither wrap nor saturate.
  localparam int AW    = XW + $clog2(N_NODES);
  localparam int HW    = XW + WW + $clog2(N_NODES) + $clog2(N_IN);
  localparam int OW    = HW + WW + $clog2(N_NODES) + $clog2(N_HID);
  localparam int CW    = $clog2(N_NODES);
  localparam int HROW  = N_HID * HW;
  localparam int OROW  = N_OUT * OW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_L1   = 2'd1;
  localparam logic [1:0] S_L2   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                       state_q, state_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic                             last_node;
  int                               node;

  logic [N_NODES*N_IN*XW-1:0]       x_q;
  logic [N_NODES*N_NODES-1:0]       adj_q;
  logic [N_IN*N_HID*WW-1:0]         w1_q;
  logic [N_HID*N_OUT*WW-1:0]        w2_q;
  logic [N_NODES*HROW-1:0]          h_q;
  logic [N_NODES*OROW-1:0]          out_q;

  logic signed [AW-1:0]             aggx [N_IN];
  logic signed [HW-1:0]             acc1;
  logic [HROW-1:0]                  hrow;
  logic signed [OW-1:0]             aggh [N_HID];
  logic signed [OW-1:0]             acc2;
  logic [OROW-1:0]                  yrow;

  // Hidden activation: negative pre-activations clamp to zero.
  function automatic logic signed [HW-1:0] relu(input logic signed [HW-1:0] v);
    return v[HW-1] ? '0 : v;
  endfunction

  // Node j contributes to node i when the adjacency bit is set; the self-loop
  // is always present, which makes the diagonal bits irrelevant.
  function automatic logic is_nbr(input logic [N_NODES*N_NODES-1:0] a,
                                  input int i, input int j);
    return a[i*N_NODES+j] || (i == j);
  endfunction

  assign node      = int'(cnt_q);
  assign last_node = (cnt_q == CW'(N_NODES - 1));
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_flat  = out_q;

  // Layer 1 for the current node: neighbour-sum features, then weight and ReLU.
  always_comb begin
    hrow = '0;
    acc1 = '0;
    for (int f = 0; f < N_IN; f++) begin
      aggx[f] = '0;
      for (int j = 0; j < N_NODES; j++) begin
        if (is_nbr(adj_q, node, j))
          aggx[f] = aggx[f] + AW'($signed(x_q[(j*N_IN+f)*XW +: XW]));
      end
    end
    for (int k = 0; k < N_HID; k++) begin
      acc1 = '0;
      for (int f = 0; f < N_IN; f++)
        acc1 = acc1 + HW'(aggx[f]) * HW'($signed(w1_q[(k*N_IN+f)*WW +: WW]));
      hrow[k*HW +: HW] = relu(acc1);
    end
  end

  // Layer 2 for the current node: neighbour-sum hidden values, then weight.
  always_comb begin
    yrow = '0;
    acc2 = '0;
    for (int k = 0; k < N_HID; k++) begin
      aggh[k] = '0;
      for (int j = 0; j < N_NODES; j++) begin
        if (is_nbr(adj_q, node, j))
          aggh[k] = aggh[k] + OW'($signed(h_q[(j*N_HID+k)*HW +: HW]));
      end
    end
    for (int o = 0; o < N_OUT; o++) begin
      acc2 = '0;
      for (int k = 0; k < N_HID; k++)
        acc2 = acc2 + aggh[k] * OW'($signed(w2_q[(o*N_HID+k)*WW +: WW]));
      yrow[o*OW +: OW] = acc2;
    end
  end

  // Job sequencing: accept, sweep nodes for layer 1, sweep for layer 2, hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_L1;
          cnt_d   = '0;
        end
      end
      S_L1: begin
        if (last_node) begin
          state_d = S_L2;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_L2: begin
        if (last_node) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Job capture, hidden register file and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      adj_q <= '0;
      w1_q  <= '0;
      w2_q  <= '0;
      h_q   <= '0;
      out_q <= '0;
    end else begin
      if (state_q == S_IDLE && in_valid) begin
        x_q   <= x_flat;
        adj_q <= adj;
        w1_q  <= w1_flat;
        w2_q  <= w2_flat;
      end
      if (state_q == S_L1) h_q[cnt_q*HROW +: HROW] <= hrow;
      if (state_q == S_L2) out_q[cnt_q*OROW +: OROW] <= yrow;
    end
  end

endmodule

// File: tb/tb_gnn_mp_engine.sv
// Directed testbench for gnn_mp_engine with default parameters.
module tb_gnn_mp_engine;

  localparam int N  = 4;
  localparam int NI = 4;
  localparam int NH = 4;
  localparam int NO = 2;
  localparam int XW = 5;
  localparam int WW = 5;
  localparam int OW = 23;
  localparam int NE = N * NO;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [N*NI*XW-1:0]   x_flat;
  logic [N*N-1:0]       adj;
  logic [NI*NH*WW-1:0]  w1_flat;
  logic [NH*NO*WW-1:0]  w2_flat;
  logic                 out_valid;
  logic                 out_ready;
  logic [N*NO*OW-1:0]   out_flat;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  gnn_mp_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_flat(x_flat), .adj(adj), .w1_flat(w1_flat), .w2_flat(w2_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_flat(out_flat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int elem(input int e);
    logic signed [OW-1:0] v;
    v = out_flat[e*OW +: OW];
    return int'(v);
  endfunction

  task automatic fill_job(input int xv, input int w1v, input int w2v, input logic [15:0] a);
    for (int i = 0; i < N*NI; i++) x_flat[i*XW +: XW] = xv[XW-1:0];
    for (int i = 0; i < NI*NH; i++) w1_flat[i*WW +: WW] = w1v[WW-1:0];
    for (int i = 0; i < NH*NO; i++) w2_flat[i*WW +: WW] = w2v[WW-1:0];
    adj = a;
  endtask

  // Handshake then wait (bounded) for out_valid; lat is the cycle index of DONE.
  task automatic run_job(output int lat);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++;
    if (out_flat !== '0) begin n_err++; $display("FAIL reset_out_flat: got %h expected 0", out_flat); end
  endtask

  task automatic test_diamond();
    int lat;
    fill_job(1, 1, 1, 16'h6996);
    out_ready = 1'b1;
    run_job(lat);
    n_cmp++;
    if (lat !== 9) begin n_err++; $display("FAIL diamond_latency: got %0d expected 9", lat); end
    for (int e = 0; e < NE; e++) begin
      n_cmp++;
      if (elem(e) !== 144) begin n_err++; $display("FAIL diamond_out[%0d]: got %0d expected 144", e, elem(e)); end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL diamond_one_cycle_valid: got %b expected 0", out_valid); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL diamond_in_ready_back: got %b expected 1", in_ready); end
  endtask

  task automatic test_relu();
    int lat;
    fill_job(1, -1, 1, 16'h6996);
    run_job(lat);
    n_cmp++;
    if (lat !== 9) begin n_err++; $display("FAIL relu_latency: got %0d expected 9", lat); end
    for (int e = 0; e < NE; e++) begin
      n_cmp++;
      if (elem(e) !== 0) begin n_err++; $display("FAIL relu_out[%0d]: got %0d expected 0", e, elem(e)); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_self_loop();
    int lat;
    fill_job(1, 1, 1, 16'h0000);
    run_job(lat);
    for (int e = 0; e < NE; e++) begin
      n_cmp++;
      if (elem(e) !== 16) begin n_err++; $display("FAIL selfloop_out[%0d]: got %0d expected 16", e, elem(e)); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_neg();
    int lat;
    fill_job(-16, -16, -16, 16'hFFFF);
    run_job(lat);
    for (int e = 0; e < NE; e++) begin
      n_cmp++;
      if (elem(e) !== -1048576) begin n_err++; $display("FAIL fullneg_out[%0d]: got %0d expected -1048576", e, elem(e)); end
    end
    @(posedge clk); #1;
  endtask

  // Only node 1 feeds node 0; node n features = n+1; output 1 weights twice output 0.
  task automatic test_directed_edge();
    int lat;
    int exp_v [NE];
    fill_job(1, 1, 1, 16'h0002);
    for (int n = 0; n < N; n++)
      for (int f = 0; f < NI; f++) x_flat[(n*NI+f)*XW +: XW] = XW'(n + 1);
    for (int k = 0; k < NH; k++) w2_flat[(1*NH+k)*WW +: WW] = WW'(2);
    exp_v = '{80, 160, 32, 64, 48, 96, 64, 128};
    run_job(lat);
    for (int e = 0; e < NE; e++) begin
      n_cmp++;
      if (elem(e) !== exp_v[e]) begin n_err++; $display("FAIL directed_out[%0d]: got %0d expected %0d", e, elem(e), exp_v[e]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [N*NO*OW-1:0] held;
    fill_job(1, 1, 1, 16'h0000);
    out_ready = 1'b0;
    run_job(lat);
    n_cmp++;
    if (lat !== 9) begin n_err++; $display("FAIL bp_latency: got %0d expected 9", lat); end
    held = out_flat;
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      fill_job(7, 3, -2, 16'hFFFF);
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_hold[%0d]: got %b expected 1", c, out_valid); end
      n_cmp++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready); end
      n_cmp++;
      if (out_flat !== held) begin n_err++; $display("FAIL bp_stable[%0d]: got %h expected %h", c, out_flat, held); end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (elem(0) !== 16) begin n_err++; $display("FAIL bp_value: got %0d expected 16", elem(0)); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_no_stray_accept: got %b expected 1", in_ready); end
  endtask

  task automatic test_reset_midjob();
    int lat;
    fill_job(1, 1, 1, 16'h6996);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    n_cmp++;
    if (out_flat !== '0) begin n_err++; $display("FAIL midrst_out_flat: got %h expected 0", out_flat); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(lat);
    n_cmp++;
    if (lat !== 9) begin n_err++; $display("FAIL midrst_latency: got %0d expected 9", lat); end
    for (int e = 0; e < NE; e++) begin
      n_cmp++;
      if (elem(e) !== 144) begin n_err++; $display("FAIL midrst_out[%0d]: got %0d expected 144", e, elem(e)); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int t0, t1, guard;
    fill_job(1, 1, 1, 16'h6996);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    t1 = cyc;
    in_valid = 1'b0;
    n_cmp++;
    if (t1 - t0 !== 10) begin n_err++; $display("FAIL b2b_period: got %0d expected 10", t1 - t0); end
    guard = 0;
    while (out_valid !== 1'b1 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    n_cmp++;
    if (guard !== 8) begin n_err++; $display("FAIL b2b_second_latency: got %0d expected 8", guard); end
    n_cmp++;
    if (elem(NE-1) !== 144) begin n_err++; $display("FAIL b2b_out: got %0d expected 144", elem(NE-1)); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    fill_job(0, 0, 0, 16'h0000);
    #12;
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_diamond();
    test_relu();
    test_self_loop();
    test_full_neg();
    test_directed_edge();
    test_backpressure();
    test_reset_midjob();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gnn_mp_engine.md
Name: gnn_mp_engine

Overview:
- Parametrised, time-multiplexed two-layer graph neural network engine.
- Generalises the fixed 4-node, hard-wired-diamond GNN top in three ways: node, feature, hidden and output counts are parameters; graph connectivity comes from a runtime adjacency matrix; the whole job is framed by a valid/ready handshake.
- Evaluates one node per cycle per layer, using a single shared layer-1 datapath and a single shared layer-2 datapath.
- Sits between the feature/weight loader and the result collector.

Parameters:
- N_NODES, 4, number of graph nodes (>=2)
- N_IN, 4, input features per node
- N_HID, 4, hidden (layer-1) features per node
- N_OUT, 2, output features per node
- XW, 5, signed input feature width
- WW, 5, signed weight width
- Derived, not overridable: AW = XW+$clog2(N_NODES); HW = XW+WW+$clog2(N_NODES)+$clog2(N_IN); OW = HW+WW+$clog2(N_NODES)+$clog2(N_HID). Defaults give AW=7, HW=14, OW=23.

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  job inputs are valid
- in_ready  out  1  engine can accept a job
- x_flat  in  N_NODES*N_IN*XW  node n, feature f at [(n*N_IN+f)*XW +: XW]
- adj  in  N_NODES*N_NODES  bit [i*N_NODES+j]=1 means node j feeds node i
- w1_flat  in  N_IN*N_HID*WW  element (f,h) at [(h*N_IN+f)*WW +: WW]
- w2_flat  in  N_HID*N_OUT*WW  element (h,o) at [(o*N_HID+h)*WW +: WW]
- out_valid  out  1  results are valid
- out_ready  in  1  consumer accepts results
- out_flat  out  N_NODES*N_OUT*OW  node n, output o at [(n*N_OUT+o)*OW +: OW], signed

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, node counter=0.
  - in_ready=1, out_valid=0, out_flat=0.
  - Hidden and input registers cleared.
  - Reset mid-job abandons the job; no partial output is ever flagged valid.
- FSM states: IDLE -> L1 -> L2 -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register x_flat, adj, w1_flat and w2_flat. Go to L1 with cnt=0.
- L1, one cycle per node i = cnt:
  - aggx[f] = sum over j with (adj[i][j] || i==j) of x[j][f]. Computed at width AW; the self-loop is always included.
  - h[i][k] = ReLU(sum_f aggx[f]*w1[f][k]). Computed at width HW; negative results become 0.
  - Write h[i] to the hidden register file. cnt++.
  - After cnt==N_NODES-1, go to L2 with cnt=0.
- L2, one cycle per node i:
  - aggh[k] = same neighbour rule applied to h.
  - y[i][o] = sum_k aggh[k]*w2[o][k], full precision at width OW, no ReLU.
  - Write y[i] into out_flat. After the last node, go to DONE.
- DONE:
  - out_valid=1; out_flat is held stable.
  - On out_ready=1, clear out_valid and go to IDLE. in_ready rises in the following cycle.
- in_ready=0 in L1, L2 and DONE. in_valid is ignored outside IDLE.
- Latency: handshake at cycle 0 -> out_valid first high at cycle 2*N_NODES+1 (9 for defaults).
- Throughput: one job per 2*N_NODES+2 cycles when out_ready is held high.
- Arithmetic:
  - All signed two's complement with sign extension before add and multiply.
  - Widths are sized for the worst case, so neither saturation nor wrap is possible.
- Boundary conditions:
  - out_ready high in the very first DONE cycle -> out_valid is high for exactly one cycle.
  - Simultaneous events never arise: a new accept cannot coincide with the DONE handshake because in_ready=0 in DONE.
  - An all-zero adj degenerates to per-node self-aggregation.
  - adj diagonal bits are don't-care.

Test Plan:
- Diamond adj (0-1, 0-2, 1-3, 2-3, symmetric), all x=1, all w1=1, all w2=1 -> each hidden=12, every out_flat element=144, out_valid at cycle 9.
- Same graph, all w1=-1 -> hidden clamped to 0 by ReLU -> all outputs 0.
- adj=0, all x=1, w1=1, w2=1 -> hidden=4, all outputs=16 (self-loop only).
- Full adj, all x=-16, w1=-16, w2=-16 -> hidden=4096, outputs=-1048576 exactly, with no overflow.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_flat stable, in_ready=0. in_valid pulses in this window are ignored.
- Assert rst_n low in the 2nd L1 cycle -> out_valid=0 and in_ready=1 immediately. A new job then completes with correct values.
